// File: rtl/fft256_bitrev_reorder.sv
// Reorders one 256-sample FFT frame from bit-reversed order into natural order.
// Two banks alternate: one fills at bit-reversed addresses while the other streams out.
module fft256_bitrev_reorder #(
    parameter int N = 256,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic         sop_in,
    input  logic [W-1:0] x_re,
    input  logic [W-1:0] x_im,
    output logic         valid_out,
    output logic         sop_out,
    output logic         eop_out,
    output logic [W-1:0] y_re,
    output logic [W-1:0] y_im,
    output logic         frame_err
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic {IDLE, FILL} wr_state_t;

    wr_state_t      state;
    wr_state_t      state_next;
    logic [AW-1:0]  wcnt;
    logic [AW-1:0]  wcnt_next;
    logic [AW-1:0]  wr_addr;
    logic           wr_en;
    logic           err_next;
    logic           frame_done;
    logic           swap_pending;
    logic           bank_sel;
    logic           wr_bank;
    logic           rd_active;
    logic [AW-1:0]  rd_addr;
    logic [2*W-1:0] mem [0:2*N-1];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // The swap lands one edge after the last write, so a sop arriving in that
    // cycle must already target the bank that is about to become the write bank.
    assign wr_bank = bank_sel ^ swap_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wcnt         <= '0;
            frame_err    <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            state        <= state_next;
            wcnt         <= wcnt_next;
            frame_err    <= err_next;
            swap_pending <= frame_done;
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        wr_en      = 1'b0;
        wr_addr    = bitrev(wcnt);
        err_next   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in && sop_in) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    wcnt_next  = AW'(1);
                    state_next = FILL;
                end
            end
            FILL: begin
                if (valid_in) begin
                    wr_en = 1'b1;
                    if (sop_in) begin
                        // A new sop mid-frame abandons the partial frame and restarts.
                        wr_addr   = '0;
                        wcnt_next = AW'(1);
                        err_next  = (wcnt != '0);
                    end else if (wcnt == LAST) begin
                        frame_done = 1'b1;
                        wcnt_next  = '0;
                        state_next = IDLE;
                    end else begin
                        wcnt_next = wcnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[{wr_bank, wr_addr}] <= {x_re, x_im};
        end
    end

    // Read engine: the bank not being written streams addresses 0..N-1 back to back.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel  <= 1'b0;
            rd_active <= 1'b0;
            rd_addr   <= '0;
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
        end else begin
            if (swap_pending) begin
                bank_sel <= ~bank_sel;
            end
            if (rd_active) begin
                {y_re, y_im} <= mem[{~bank_sel, rd_addr}];
                valid_out    <= 1'b1;
                sop_out      <= (rd_addr == '0);
                eop_out      <= (rd_addr == LAST);
            end else begin
                valid_out <= 1'b0;
                sop_out   <= 1'b0;
                eop_out   <= 1'b0;
            end
            if (swap_pending) begin
                rd_active <= 1'b1;
                rd_addr   <= '0;
            end else if (rd_active) begin
                rd_addr <= rd_addr + 1'b1;
                if (rd_addr == LAST) begin
                    rd_active <= 1'b0;
                end
            end
        end
    end
endmodule
